// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - decode stage: instruction decode, register file and D/E pipeline register
// Reads are write-through so writeback and decode of a dependent instruction can share a cycle.
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        ResultSrcE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RD_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0]  opcode;
  logic [4:0]  rdD, rs1D, rs2D;
  logic [2:0]  funct3;
  logic        funct7b5;

  assign opcode   = InstrD[6:0];
  assign rdD      = InstrD[11:7];
  assign funct3   = InstrD[14:12];
  assign rs1D     = InstrD[19:15];
  assign rs2D     = InstrD[24:20];
  assign funct7b5 = InstrD[30];

  logic        regWriteD, aluSrcD, memWriteD, resultSrcD, branchD;
  logic [2:0]  aluControlD, aluFunctD;
  logic [31:0] immExtD;

  always_comb begin
    aluFunctD = ALU_ADD;
    case (funct3)
      3'b000:  aluFunctD = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  aluFunctD = ALU_SLT;
      3'b110:  aluFunctD = ALU_OR;
      3'b111:  aluFunctD = ALU_AND;
      default: aluFunctD = ALU_ADD;
    endcase
  end

  always_comb begin
    regWriteD   = 1'b0;
    aluSrcD     = 1'b0;
    memWriteD   = 1'b0;
    resultSrcD  = 1'b0;
    branchD     = 1'b0;
    aluControlD = ALU_ADD;
    immExtD     = 32'd0;
    case (opcode)
      OP_LW: begin
        regWriteD  = 1'b1;
        aluSrcD    = 1'b1;
        resultSrcD = 1'b1;
        immExtD    = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_SW: begin
        memWriteD = 1'b1;
        aluSrcD   = 1'b1;
        immExtD   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_R: begin
        regWriteD   = 1'b1;
        aluControlD = aluFunctD;
      end
      OP_IALU: begin
        regWriteD   = 1'b1;
        aluSrcD     = 1'b1;
        aluControlD = aluFunctD;
        immExtD     = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_BEQ: begin
        branchD     = 1'b1;
        aluControlD = ALU_SUB;
        immExtD     = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (RegWriteW && RDW != 5'd0) begin
      regs[RDW] <= ResultW;
    end
  end

  // x0 is forced to zero on read, so the stored x0 entry is never consulted.
  logic [31:0] rd1D, rd2D;

  always_comb begin
    if (rs1D == 5'd0)                       rd1D = 32'd0;
    else if (RegWriteW && RDW == rs1D)      rd1D = ResultW;
    else                                    rd1D = regs[rs1D];
    if (rs2D == 5'd0)                       rd2D = 32'd0;
    else if (RegWriteW && RDW == rs2D)      rd2D = ResultW;
    else                                    rd2D = regs[rs2D];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      RD1_E       <= 32'd0;
      RD2_E       <= 32'd0;
      Imm_Ext_E   <= 32'd0;
      PCE         <= 32'd0;
      PCPlus4E    <= 32'd0;
      RD_E        <= 5'd0;
      RS1_E       <= 5'd0;
      RS2_E       <= 5'd0;
    end else begin
      // A flush turns the slot into a bubble; operand/index fields are harmless to keep.
      if (FlushE) begin
        RegWriteE   <= 1'b0;
        ALUSrcE     <= 1'b0;
        MemWriteE   <= 1'b0;
        ResultSrcE  <= 1'b0;
        BranchE     <= 1'b0;
        ALUControlE <= 3'b000;
      end else begin
        RegWriteE   <= regWriteD;
        ALUSrcE     <= aluSrcD;
        MemWriteE   <= memWriteD;
        ResultSrcE  <= resultSrcD;
        BranchE     <= branchD;
        ALUControlE <= aluControlD;
      end
      RD1_E     <= rd1D;
      RD2_E     <= rd2D;
      Imm_Ext_E <= immExtD;
      PCE       <= PCD;
      PCPlus4E  <= PCPlus4D;
      RD_E      <= rdD;
      RS1_E     <= rs1D;
      RS2_E     <= rs2D;
    end
  end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, register file fixed at 32 entries.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 InstrD  in  32  instruction from fetch stage.
REQ-005 PCD, PCPlus4D  in  32 each  PC and PC+4 of InstrD.
REQ-006 RegWriteW  in  1  writeback enable; RDW  in  5  writeback register; ResultW  in  32  writeback data.
REQ-007 FlushE  in  1  squash the instruction entering execute.
REQ-008 RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  registered control to execute.
REQ-009 ALUControlE  out  3  registered ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-010 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  32 each; RD_E, RS1_E, RS2_E  out  5 each; all registered.

Function
REQ-011 Decode fields: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7b5 [30].
REQ-012 Opcode decode:
- 0000011 lw: RegWrite=1, ALUSrc=1, ResultSrc=1, imm I.
- 0100011 sw: MemWrite=1, ALUSrc=1, imm S.
- 0110011 R-type: RegWrite=1.
- 0010011 I-ALU: RegWrite=1, ALUSrc=1, imm I.
- 1100011 beq: Branch=1, imm B, ALUControl sub.
- any other opcode: all control 0, ALUControl 000.
REQ-013 ALUControl: lw/sw -> add; R/I-ALU by funct3: 000 -> sub only if R-type and funct7b5=1, else add; 010 slt; 110 or; 111 and; other funct3 -> add.
REQ-014 Immediates sign-extended from InstrD[31]: I = [31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; other opcodes -> 0.
REQ-015 Register file 32x32; write at rising edge when RegWriteW=1 and RDW!=0; writes to x0 discarded; x0 reads 0.
REQ-016 Reads combinational with write-through: if RegWriteW=1, RDW!=0 and RDW equals rs1/rs2, that read returns ResultW in the same cycle.
REQ-017 Latency: all E outputs reflect InstrD/PCD/PCPlus4D exactly one rising edge later.
REQ-018 FlushE=1 at an edge: all E control outputs (RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE) and ALUControlE load 0; data/index outputs may load normally; register-file write in the same cycle still occurs.
REQ-019 Simultaneous writeback to a register and flush: write completes; flush affects only E registers.

Reset
REQ-020 rst=0 asynchronously clears all E outputs to 0 and all 32 register-file entries to 0, independent of clk.
REQ-021 While rst=0 writebacks are ignored; first capture on first rising edge after rst returns to 1.
REQ-022 Reset asserted mid-operation discards the in-flight E contents; no partial state survives.

Verification
REQ-023 Reset: rst=0 with random inputs -> all outputs 0 immediately; after release, RD1_E for any rs1 reads 0.
REQ-024 InstrD=0x00A00293 (addi x5,x0,10), PCD=0x10 -> next edge: RegWriteE=1, ALUSrcE=1, ALUControlE=000, Imm_Ext_E=0x0000000A, RD_E=5, PCE=0x10, PCPlus4E=0x14.
REQ-025 InstrD=0xFFC4A303 (lw x6,-4(x9)) -> ResultSrcE=1, Imm_Ext_E=0xFFFFFFFC, RS1_E=9, RD_E=6; InstrD=0x00612423 (sw x6,8(x2)) -> MemWriteE=1, RegWriteE=0, Imm_Ext_E=0x00000008, RS2_E=6.
REQ-026 Write-through: RegWriteW=1, RDW=1, ResultW=0x12345678 while InstrD=0x402083B3 (sub x7,x1,x2) -> next edge RD1_E=0x12345678, ALUControlE=001, RD2_E=old x2.
REQ-027 x0 protection: RegWriteW=1, RDW=0, ResultW=0xFFFFFFFF, then read rs1=0 -> RD1_E=0.
REQ-028 Flush: InstrD=0x00A00293 with FlushE=1 -> RegWriteE=0, ALUSrcE=0, ALUControlE=000; concurrent writeback RDW=3 still visible on later read of x3.
